// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and state type for the sequential divider
package div_pkg;

  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  typedef enum logic {
    IDLE,
    CALC
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
  parameter int DIVISOR_W = div_pkg::DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   pr_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   pr_out,
  output logic                 q_bit
);

  // Shift the next dividend bit into the partial remainder, subtract when it fits.
  // The shifted value is kept one bit wider than PR so the compare can never wrap.
  logic [DIVISOR_W+1:0] shifted;

  // Trial subtraction and restore selection
  always_comb begin
    shifted = {pr_in, bit_in};
    q_bit   = (shifted >= {2'b00, divisor});
    pr_out  = q_bit ? (DIVISOR_W+1)'(shifted - {2'b00, divisor})
                    : shifted[DIVISOR_W:0];
  end

endmodule

// File: rtl/seq_divider_32by16.sv
// rtl/seq_divider_32by16.sv - iterative radix-2 restoring divider, one quotient bit per clock
module seq_divider_32by16 #(
  parameter int DIVIDEND_W = div_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = div_pkg::DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  import div_pkg::*;

  localparam int CNT_BITS = $clog2(DIVIDEND_W);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(DIVIDEND_W - 1);

  div_state_t state, state_n;

  // The dividend shift register doubles as the quotient accumulator: as dividend
  // bits leave at the top, quotient bits enter at the bottom.
  logic [DIVIDEND_W-1:0] shreg, shreg_n;
  logic [DIVISOR_W:0]    pr, pr_n;
  logic [DIVISOR_W-1:0]  dvsr, dvsr_n;
  logic [CNT_BITS-1:0]   cnt, cnt_n;
  logic                  busy_n, done_n, dbz_n;
  logic [DIVIDEND_W-1:0] quotient_n;
  logic [DIVISOR_W-1:0]  remainder_n;

  logic [DIVISOR_W:0]    step_pr;
  logic                  step_q;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .pr_in   (pr),
    .bit_in  (shreg[DIVIDEND_W-1]),
    .divisor (dvsr),
    .pr_out  (step_pr),
    .q_bit   (step_q)
  );

  // Next-state and register-update decisions for the IDLE/CALC machine
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    pr_n        = pr;
    dvsr_n      = dvsr;
    cnt_n       = cnt;
    busy_n      = busy;
    done_n      = 1'b0;
    quotient_n  = quotient;
    remainder_n = remainder;
    dbz_n       = div_by_zero;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // Resolved immediately; no iteration needed.
            quotient_n  = '1;
            remainder_n = dividend[DIVISOR_W-1:0];
            dbz_n       = 1'b1;
            done_n      = 1'b1;
          end else begin
            shreg_n = dividend;
            pr_n    = '0;
            dvsr_n  = divisor;
            cnt_n   = '0;
            busy_n  = 1'b1;
            state_n = CALC;
          end
        end
      end
      CALC: begin
        shreg_n = {shreg[DIVIDEND_W-2:0], step_q};
        pr_n    = step_pr;
        cnt_n   = cnt + 1'b1;
        if (cnt == LAST_CNT) begin
          quotient_n  = {shreg[DIVIDEND_W-2:0], step_q};
          remainder_n = step_pr[DIVISOR_W-1:0];
          dbz_n       = 1'b0;
          done_n      = 1'b1;
          busy_n      = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight division
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      pr          <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      pr          <= pr_n;
      dvsr        <= dvsr_n;
      cnt         <= cnt_n;
      busy        <= busy_n;
      done        <= done_n;
      quotient    <= quotient_n;
      remainder   <= remainder_n;
      div_by_zero <= dbz_n;
    end
  end

endmodule

// File: doc/seq_divider_32by16.md
# seq_divider_32by16

Sequential radix-2 restoring divider: 32-bit dividend by 16-bit divisor, producing a 32-bit quotient and a 16-bit remainder. It is the inverse companion to the 16×16 Karatsuba multiplier: it recovers one operand from a product and the other operand, and it is used to cross-check multiplier results in hardware. Iterative, one quotient bit per clock, with a start/busy/done handshake.

## Interface
- `DIVIDEND_W`, default 32, dividend and quotient width.
- `DIVISOR_W`, default 16, divisor and remainder width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a division. Sampled on a rising edge only when `busy`=0.
- `dividend`  in  DIVIDEND_W  captured on the accepting edge.
- `divisor`  in  DIVISOR_W  captured on the accepting edge.
- `busy`  out  1  division in progress.
- `done`  out  1  one-cycle pulse; results are valid from this pulse onward.
- `quotient`  out  DIVIDEND_W  result; held until the next accepted start.
- `remainder`  out  DIVISOR_W  result; held until the next accepted start.
- `div_by_zero`  out  1  set with `done` when the divisor was 0; held like the results.

## Operation
- States: IDLE and CALC.
- **IDLE, `start`=1, divisor≠0:**
  - Load the dividend into the shift register.
  - Clear the 17-bit partial remainder (PR).
  - Set the bit counter to 0, set `busy`=1, move to CALC.
- **IDLE, `start`=1, divisor=0:**
  - Stay in IDLE. `busy` stays 0.
  - Write `quotient`=all ones, `remainder`=`dividend[DIVISOR_W-1:0]`.
  - Set `div_by_zero`=1 and `done`=1 on that same edge.
- **CALC, each edge:**
  - PR' = {PR[15:0], dividend MSB}. Shift the dividend left by one.
  - If PR' ≥ {1'b0, divisor}: PR = PR' − divisor and shift quotient bit 1 in. Otherwise PR = PR' and shift in 0.
  - The counter increments.
  - On the 32nd CALC edge (counter = 31): write `quotient`/`remainder`, set `div_by_zero`=0 and `done`=1, clear `busy`, return to IDLE.
- PR is 17 bits so the compare never overflows. The final remainder is PR[15:0] and is always < divisor.
- **`start` while `busy`=1:** ignored. Operands are not re-sampled and the in-flight division is unaffected.
- **`start` in the cycle `done` is high:** accepted, because `busy`=0. `done` drops on the next edge, except that a divide-by-zero start re-pulses it.
- **`rst`:** state=IDLE; `busy`, `done`, `div_by_zero`, `quotient`, `remainder` and all internal registers are cleared to 0. This applies mid-CALC too: the in-flight division is discarded and no `done` is issued.
- `rst` has priority over `start` on the same edge.

## Timing
- Start accepted at edge E0. CALC edges are E1..E32. `done` is high for the cycle after E32, and `busy` is high from after E0 to after E32 (32 cycles).
- Latency from the accepting edge to `done` is 32 clocks. Throughput is one division per 32 clocks; back-to-back is possible by asserting `start` during `done`.
- Divide-by-zero latency: `done` is high in the cycle after E0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `div_pkg` holds:
  - `DIVIDEND_W` and `DIVISOR_W` constants.
  - State enum `div_state_t` {IDLE, CALC}.
  - Counter width localparam `$clog2(DIVIDEND_W)`.
- Optional sub-module `div_step`: a combinational single restoring step. Inputs PR, next dividend bit, divisor. Outputs new PR and quotient bit. The top level is the FSM, counter and registers.

## Test plan
- 0x0626_0060 / 0x5678 (product 0x1234×0x5678) → quotient 0x0000_1234, remainder 0x0000, `done` exactly 32 clocks after the start edge.
- 0x0000_0064 / 0x0007 → quotient 0x0000_000E, remainder 0x0002; then 0xFFFF_FFFF / 0x0001 → quotient 0xFFFF_FFFF, remainder 0.
- 0x1234_5678 / 0x0000 → quotient 0xFFFF_FFFF, remainder 0x5678, `div_by_zero`=1, `done` one clock after start, `busy` never set.
- Start 0x0000_0F00 / 0x0010; pulse `start` with 0xFFFF_FFFF / 0x0003 at CALC cycle 5 → ignored. Result quotient 0x0000_00F0, remainder 0.
- `rst` asserted at CALC cycle 10 → next cycle all outputs 0, `busy`=0, and no `done` afterwards. A fresh start then completes correctly.
- Back-to-back: `start` held during `done` with new operands → second `done` 32 clocks later. Random sweep of 10k operand pairs checked against `/` and `%`.
